// File: rtl/game_pkg.sv
// Shared types and constants for the Cat vs Dog game blocks.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    AIM     = 3'd1,
    CHARGE  = 3'd2,
    THROW   = 3'd3,
    RESOLVE = 3'd4,
    GAP     = 3'd5,
    OVER    = 3'd6
  } sched_state_t;

  typedef enum logic {
    CAT = 1'b0,
    DOG = 1'b1
  } player_t;

  localparam int unsigned WIND_NEUTRAL = 50;
  localparam int unsigned WIND_MAX     = 100;
  localparam int unsigned HP_W         = 3;
  localparam int unsigned FORCE_W      = 10;
  localparam int unsigned WIND_W       = 7;
  localparam int unsigned LFSR_W       = 16;
  localparam int unsigned CNT_W        = 32;

endpackage

// File: rtl/wind_lfsr.sv
// Free-running 16-bit Fibonacci LFSR folded into a 0..100 wind value, latched on draw.
module wind_lfsr
  import game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              draw,
  output logic [WIND_W-1:0] wind_next,
  output logic [WIND_W-1:0] wind
);

  // Values above WIND_MAX are pulled back by the excess of the 7-bit range over it.
  localparam int unsigned WIND_FOLD = (1 << WIND_W) - WIND_MAX;

  logic [LFSR_W-1:0] lfsr_q;
  logic              feedback;
  logic [WIND_W-1:0] sample;

  assign feedback  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign sample    = lfsr_q[WIND_W-1:0];
  assign wind_next = (sample <= WIND_W'(WIND_MAX)) ? sample : sample - WIND_W'(WIND_FOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
      wind   <= WIND_W'(WIND_NEUTRAL);
    end else begin
      lfsr_q <= {lfsr_q[LFSR_W-2:0], feedback};
      if (draw) begin
        wind <= wind_next;
      end
    end
  end

endmodule

// File: rtl/turn_scheduler.sv
// Turn sequencer: alternates cat/dog throws, measures fire-button force, tracks hp and winner.
module turn_scheduler
  import game_pkg::*;
#(
  parameter int unsigned       CHARGE_DIV = 65536,
  parameter int unsigned       FORCE_MAX  = 1023,
  parameter int unsigned       HP_INIT    = 3,
  parameter int unsigned       GAP_CYCLES = 65000000,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_game,
  input  logic               fire_btn,
  input  logic               done_cat,
  input  logic               done_dog,
  input  logic               hit_by_cat,
  input  logic               hit_by_dog,
  output logic               enable_cat,
  output logic               enable_dog,
  output logic [FORCE_W-1:0] throw_force,
  output logic [WIND_W-1:0]  wind_force,
  output logic               turn,
  output logic [HP_W-1:0]    hp_cat,
  output logic [HP_W-1:0]    hp_dog,
  output logic               charging,
  output logic               game_over,
  output logic               winner
);

  sched_state_t       state_q, state_d;
  player_t            turn_q, turn_d, winner_q, winner_d;
  logic [FORCE_W-1:0] force_q, force_d;
  logic [CNT_W-1:0]   presc_q, presc_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [HP_W-1:0]    hp_cat_q, hp_cat_d, hp_dog_q, hp_dog_d;
  logic               hit_q, hit_d;
  logic               fire_prev_q;
  logic               draw;
  logic               active_hit, active_done;
  logic [HP_W-1:0]    opp_hp, opp_hp_new;

  wind_lfsr #(.SEED(LFSR_SEED)) u_wind (
    .clk       (clk),
    .rst_n     (rst_n),
    .draw      (draw),
    .wind_next (),
    .wind      (wind_force)
  );

  assign active_hit  = (turn_q == DOG) ? hit_by_dog : hit_by_cat;
  assign active_done = (turn_q == DOG) ? done_dog : done_cat;
  assign opp_hp      = (turn_q == DOG) ? hp_cat_q : hp_dog_q;
  assign opp_hp_new  = (hit_q && opp_hp != '0) ? opp_hp - HP_W'(1) : opp_hp;

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    turn_d   = turn_q;
    winner_d = winner_q;
    force_d  = force_q;
    presc_d  = presc_q;
    gap_d    = gap_q;
    hp_cat_d = hp_cat_q;
    hp_dog_d = hp_dog_q;
    hit_d    = hit_q;
    draw     = 1'b0;

    case (state_q)
      IDLE, OVER: begin
        if (start_game) begin
          hp_cat_d = HP_W'(HP_INIT);
          hp_dog_d = HP_W'(HP_INIT);
          turn_d   = CAT;
          hit_d    = 1'b0;
          draw     = 1'b1;
          state_d  = AIM;
        end
      end
      AIM: begin
        if (fire_btn && !fire_prev_q) begin
          force_d = '0;
          presc_d = '0;
          hit_d   = 1'b0;
          state_d = CHARGE;
        end
      end
      CHARGE: begin
        if (!fire_btn) begin
          state_d = THROW;
        end else if (presc_q == CNT_W'(CHARGE_DIV - 1)) begin
          presc_d = '0;
          if (force_q != FORCE_W'(FORCE_MAX)) begin
            force_d = force_q + FORCE_W'(1);
          end
        end else begin
          presc_d = presc_q + CNT_W'(1);
        end
      end
      THROW: begin
        if (active_hit) begin
          hit_d = 1'b1;
        end
        if (active_done) begin
          state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        if (turn_q == DOG) begin
          hp_cat_d = opp_hp_new;
        end else begin
          hp_dog_d = opp_hp_new;
        end
        if (opp_hp_new == '0) begin
          winner_d = turn_q;
          state_d  = OVER;
        end else begin
          hit_d   = 1'b0;
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q >= CNT_W'(GAP_CYCLES - 1)) begin
          turn_d  = (turn_q == CAT) ? DOG : CAT;
          force_d = '0;
          draw    = 1'b1;
          state_d = AIM;
        end else begin
          gap_d = gap_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      turn_q      <= CAT;
      winner_q    <= CAT;
      force_q     <= '0;
      presc_q     <= '0;
      gap_q       <= '0;
      hp_cat_q    <= HP_W'(HP_INIT);
      hp_dog_q    <= HP_W'(HP_INIT);
      hit_q       <= 1'b0;
      fire_prev_q <= 1'b0;
      enable_cat  <= 1'b0;
      enable_dog  <= 1'b0;
      charging    <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state_q     <= state_d;
      turn_q      <= turn_d;
      winner_q    <= winner_d;
      force_q     <= force_d;
      presc_q     <= presc_d;
      gap_q       <= gap_d;
      hp_cat_q    <= hp_cat_d;
      hp_dog_q    <= hp_dog_d;
      hit_q       <= hit_d;
      fire_prev_q <= fire_btn;
      enable_cat  <= (state_d == THROW) && (turn_d == CAT);
      enable_dog  <= (state_d == THROW) && (turn_d == DOG);
      charging    <= (state_d == CHARGE);
      game_over   <= (state_d == OVER);
    end
  end

  assign throw_force = force_q;
  assign turn        = turn_q;
  assign winner      = winner_q;
  assign hp_cat      = hp_cat_q;
  assign hp_dog      = hp_dog_q;

endmodule
